// File: rtl/calc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the calculator datapath.
// Drives immediate fields, mux/add-sub controls and register write enables.
module calc_control_unit #(
  parameter int INSTR_W  = 35,
  parameter int IMM_W    = 16,
  parameter int PC_INC   = 1,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               alu_overflow,
  output logic [IMM_W-1:0]   imm_a,
  output logic [IMM_W-1:0]   imm_b,
  output logic               novel_sel,
  output logic               subtract,
  output logic               accum_wrenable,
  output logic               pc_wrenable,
  output logic [31:0]        pc_incr,
  output logic               busy,
  output logic               halted,
  output logic               error,
  output logic               ovf_flag,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_ADDA = 3'b011;
  localparam logic [2:0] OP_SUBA = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [2:0]         ir_op_reg;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [IMM_W-1:0]   imm_a_reg;
  logic [IMM_W-1:0]   imm_b_reg;
  logic               novel_sel_reg;
  logic               subtract_reg;
  logic               accum_we_reg;
  logic               pc_we_reg;
  logic               imem_req_reg;
  logic               busy_reg;
  logic               halted_reg;
  logic               error_reg;
  logic               ovf_flag_reg;
  logic [CNT_W-1:0]   instr_count_reg;

  logic [2:0]         fetch_op;
  logic [IMM_W-1:0]   fetch_imm_a;
  logic [IMM_W-1:0]   fetch_imm_b;
  logic               op_is_alu;
  logic               op_writes_acc;

  assign fetch_op    = imem_instr[INSTR_W-1 -: 3];
  assign fetch_imm_a = imem_instr[2*IMM_W-1 -: IMM_W];
  assign fetch_imm_b = imem_instr[IMM_W-1:0];

  assign op_is_alu     = (ir_op_reg == OP_ADDI) || (ir_op_reg == OP_SUBI) ||
                         (ir_op_reg == OP_ADDA) || (ir_op_reg == OP_SUBA);
  assign op_writes_acc = op_is_alu || (ir_op_reg == OP_LDI);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FETCH;
      FETCH: begin
        if (imem_valid)                              state_next = DECODE;
        else if (wait_cnt_reg == WAIT_W'(MAX_WAIT))  state_next = ERROR;
      end
      DECODE:  state_next = (ir_op_reg == OP_ILL) ? ERROR : EXEC;
      EXEC:    state_next = (ir_op_reg == OP_HALT) ? HALT : FETCH;
      HALT:    if (start) state_next = FETCH;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Status and enable outputs are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ir_op_reg       <= OP_NOP;
      wait_cnt_reg    <= '0;
      imm_a_reg       <= '0;
      imm_b_reg       <= '0;
      novel_sel_reg   <= 1'b0;
      subtract_reg    <= 1'b0;
      accum_we_reg    <= 1'b0;
      pc_we_reg       <= 1'b0;
      imem_req_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      halted_reg      <= 1'b0;
      error_reg       <= 1'b0;
      ovf_flag_reg    <= 1'b0;
      instr_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      imem_req_reg <= (state_next == FETCH);
      busy_reg     <= (state_next == FETCH) || (state_next == DECODE) || (state_next == EXEC);
      halted_reg   <= (state_next == HALT);
      error_reg    <= (state_next == ERROR);
      accum_we_reg <= (state_next == EXEC) && op_writes_acc;
      pc_we_reg    <= (state_next == EXEC) && (ir_op_reg != OP_HALT);

      case (state_reg)
        FETCH: begin
          if (imem_valid) begin
            ir_op_reg     <= fetch_op;
            wait_cnt_reg  <= '0;
            imm_a_reg     <= fetch_imm_a;
            imm_b_reg     <= (fetch_op == OP_LDI) ? '0 : fetch_imm_b;
            novel_sel_reg <= (fetch_op == OP_ADDI) || (fetch_op == OP_SUBI) ||
                             (fetch_op == OP_LDI);
            subtract_reg  <= (fetch_op == OP_SUBI) || (fetch_op == OP_SUBA);
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        EXEC: begin
          if (ir_op_reg != OP_HALT) instr_count_reg <= instr_count_reg + CNT_W'(1);
          if (op_is_alu && alu_overflow) ovf_flag_reg <= 1'b1;
          wait_cnt_reg <= '0;
        end
        default: wait_cnt_reg <= '0;
      endcase
    end
  end

  // Reset suppresses the enables combinationally so an aborted EXEC writes nothing.
  assign accum_wrenable = accum_we_reg & ~reset;
  assign pc_wrenable    = pc_we_reg & ~reset;

  assign imem_req    = imem_req_reg;
  assign imm_a       = imm_a_reg;
  assign imm_b       = imm_b_reg;
  assign novel_sel   = novel_sel_reg;
  assign subtract    = subtract_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;
  assign error       = error_reg;
  assign ovf_flag    = ovf_flag_reg;
  assign instr_count = instr_count_reg;
  assign pc_incr     = 32'(PC_INC);

endmodule
